// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Covers fetch FSM states, next-PC select codes and the IF/ID payload layout.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP,
        PC_INC,
        PC_LOAD
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcadd4;
        logic [XLEN-1:0] instr;
    } fetch_payload_t;

    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
    localparam logic [XLEN-1:0] WORD_MASK    = {{(XLEN-2){1'b1}}, 2'b00};

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// PC register with next-PC mux: hold, step by one word, or load a word-aligned target.
module if_pc_gen
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4_c
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Increment wraps modulo 2^32.
    assign pc_plus4_c = pc_q + PC_STEP;
    assign pc         = pc_q;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_INC:  pc_d = pc_plus4_c;
            PC_LOAD: pc_d = align_word(load_pc);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem handshake and feeds IF/ID.
// Optional perf counters (fetch_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IF_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_en,
    input  logic [31:0]      redirect_pc,
    input  logic             id_stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_out,
    output logic [31:0]      pcadd4_out,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    output logic             fetch_stall,
`ifdef IF_PERF_CNT_EN
    output logic             fetch_flush,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`else
    output logic             fetch_flush
`endif
);

    fetch_state_e    state_q, state_d;
    fetch_payload_t  pay_q, pay_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            stall_q, stall_d;
    logic            flush_q, flush_d;

    pc_sel_e         pc_sel;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4_c;
    logic            accept_c;

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .pc_sel     (pc_sel),
        .load_pc    (load_pc),
        .pc         (pc),
        .pc_plus4_c (pc_plus4_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Redirect beats ack and id_stall in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: state_d = redirect_en ? FETCH : WAIT;
            WAIT: begin
                if (redirect_en)   state_d = imem_ack ? FETCH : DRAIN;
                else if (imem_ack) state_d = id_stall ? HOLD : FETCH;
            end
            HOLD:    if (redirect_en || !id_stall) state_d = FETCH;
            DRAIN:   if (imem_ack) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Datapath and registered-output updates for the current state.
    always_comb begin
        req_d    = 1'b0;
        addr_d   = addr_q;
        tgt_d    = tgt_q;
        pay_d    = pay_q;
        valid_d  = valid_q;
        stall_d  = 1'b1;
        flush_d  = redirect_en;
        pc_sel   = PC_KEEP;
        load_pc  = redirect_pc;
        accept_c = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_en) begin
                    pc_sel = PC_LOAD;
                end else begin
                    req_d  = 1'b1;
                    addr_d = pc;
                end
            end
            WAIT: begin
                if (redirect_en) begin
                    if (imem_ack) begin
                        pc_sel = PC_LOAD;
                    end else begin
                        req_d = 1'b1;
                        tgt_d = align_word(redirect_pc);
                    end
                end else if (imem_ack) begin
                    accept_c = 1'b1;
                    if (!id_stall) pc_sel = PC_INC;
                end else begin
                    req_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_en)    pc_sel = PC_LOAD;
                else if (!id_stall) pc_sel = PC_INC;
            end
            DRAIN: begin
                // In-flight data belongs to the abandoned path and is dropped.
                if (imem_ack) begin
                    pc_sel  = PC_LOAD;
                    load_pc = redirect_en ? redirect_pc : tgt_q;
                end else begin
                    req_d = 1'b1;
                    if (redirect_en) tgt_d = align_word(redirect_pc);
                end
            end
            default: ;
        endcase

        if (accept_c) begin
            pay_d.pc     = pc;
            pay_d.pcadd4 = pc_plus4_c;
            pay_d.instr  = imem_rdata;
            valid_d      = 1'b1;
            stall_d      = 1'b0;
        end
        if (redirect_en) begin
            pay_d.instr = BUBBLE_INSTR;
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
            pay_q   <= '0;
            valid_q <= 1'b0;
            stall_q <= 1'b1;
            flush_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            pay_q   <= pay_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc_out      = pay_q.pc;
    assign pcadd4_out  = pay_q.pcadd4;
    assign instr_out   = pay_q.instr;
    assign instr_valid = valid_q;
    assign fetch_stall = stall_q;
    assign fetch_flush = flush_q;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Free-running counters; wrap silently.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + CNT_W'(accept_c && !redirect_en);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; memory responses are driven by hand.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pcadd4_out;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_stall;
    logic        fetch_flush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .id_stall    (id_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .pcadd4_out  (pcadd4_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
`ifdef IF_PERF_CNT_EN
        .fetch_flush (fetch_flush),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`else
        .fetch_flush (fetch_flush)
`endif
    );

    task automatic apply_reset;
        rst = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        id_stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(output logic ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 20);
        ok = imem_req;
    endtask

    task automatic ack_now(input logic [31:0] data);
        imem_ack = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (fetch_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", fetch_flush); end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b exp 1", fetch_stall); end
        checks++; if ({pc_out, pcadd4_out, instr_out} !== 96'h0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0 0 0", pc_out, pcadd4_out, instr_out); end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        logic ok;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            wait_req(ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL seq_req%0d got timeout exp imem_req=1", i); end
            checks++; if (imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 32'(i * 4)); end
            ack_now(32'hA000_0000 + 32'(i));
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b exp 1", i, instr_valid); end
            checks++; if (pc_out !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, pc_out, 32'(i * 4)); end
            checks++; if (pcadd4_out !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pc4_%0d got %h exp %h", i, pcadd4_out, 32'(i * 4 + 4)); end
            checks++; if (instr_out !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL seq_instr%0d got %h exp %h", i, instr_out, 32'hA000_0000 + 32'(i)); end
            checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL seq_stall%0d got %b exp 0", i, fetch_stall); end
        end
    endtask

    task automatic test_ack_delay;
        logic ok;
        apply_reset();
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL dly_req got req=%b addr=%h exp req=1 addr=0", ok, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL dly_hold%0d got req=%b addr=%h exp req=1 addr=0", i, imem_req, imem_addr); end
            checks++; if ({fetch_stall, instr_valid} !== 2'b10) begin errors++; $display("FAIL dly_stall%0d got stall=%b valid=%b exp 1 0", i, fetch_stall, instr_valid); end
        end
        ack_now(32'hB00B_0000);
        checks++; if ({instr_valid, fetch_stall, imem_req} !== 3'b100) begin errors++; $display("FAIL dly_done got valid=%b stall=%b req=%b exp 1 0 0", instr_valid, fetch_stall, imem_req); end
        checks++; if (instr_out !== 32'hB00B_0000 || pc_out !== 32'h0) begin errors++; $display("FAIL dly_data got %h@%h exp b00b0000@0", instr_out, pc_out); end
    endtask

    task automatic test_id_stall;
        logic ok;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            wait_req(ok);
            ack_now(32'h1111_0000 + 32'(i));
        end
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stl_req got req=%b addr=%h exp req=1 addr=8", ok, imem_addr); end
        id_stall = 1'b1;
        ack_now(32'hC000_0008);
        checks++; if ({instr_valid, imem_req} !== 2'b10 || pc_out !== 32'h8 || instr_out !== 32'hC000_0008) begin errors++; $display("FAIL stl_cap got valid=%b req=%b pc=%h instr=%h exp 1 0 8 c0000008", instr_valid, imem_req, pc_out, instr_out); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({imem_req, fetch_stall, instr_valid} !== 3'b011 || pc_out !== 32'h8) begin errors++; $display("FAIL stl_hold%0d got req=%b stall=%b valid=%b pc=%h exp 0 1 1 8", i, imem_req, fetch_stall, instr_valid, pc_out); end
        end
        id_stall = 1'b0;
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stl_next got req=%b addr=%h exp req=1 addr=c", ok, imem_addr); end
    endtask

    task automatic test_redirect_wait;
        logic ok;
        apply_reset();
        wait_req(ok);
        ack_now(32'h2222_0000);
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL rdw_req got req=%b addr=%h exp req=1 addr=4", ok, imem_addr); end
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect_en = 1'b0;
        checks++; if ({fetch_flush, instr_valid, imem_req} !== 3'b101 || instr_out !== 32'h0) begin errors++; $display("FAIL rdw_flush got flush=%b valid=%b req=%b instr=%h exp 1 0 1 0", fetch_flush, instr_valid, imem_req, instr_out); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rdw_addr_stable got %h exp 4", imem_addr); end
        @(negedge clk);
        checks++; if ({fetch_flush, imem_req} !== 2'b01) begin errors++; $display("FAIL rdw_drain got flush=%b req=%b exp 0 1", fetch_flush, imem_req); end
        ack_now(32'hDEAD_BEEF);
        checks++; if ({instr_valid, imem_req, fetch_flush} !== 3'b000 || instr_out !== 32'h0) begin errors++; $display("FAIL rdw_discard got valid=%b req=%b flush=%b instr=%h exp 0 0 0 0", instr_valid, imem_req, fetch_flush, instr_out); end
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdw_target got req=%b addr=%h exp req=1 addr=100", ok, imem_addr); end
        ack_now(32'h0000_1234);
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h1234) begin errors++; $display("FAIL rdw_fetch got valid=%b pc=%h instr=%h exp 1 100 1234", instr_valid, pc_out, instr_out); end
    endtask

    task automatic test_redirect_priority;
        logic ok;
        apply_reset();
        wait_req(ok);
        ack_now(32'h3333_0000);
        wait_req(ok);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0203;
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_5555;
        id_stall = 1'b1;
        @(negedge clk);
        redirect_en = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        id_stall = 1'b0;
        checks++; if ({fetch_flush, instr_valid, imem_req, fetch_stall} !== 4'b1001 || instr_out !== 32'h0) begin errors++; $display("FAIL pri_win got flush=%b valid=%b req=%b stall=%b instr=%h exp 1 0 0 1 0", fetch_flush, instr_valid, imem_req, fetch_stall, instr_out); end
        @(negedge clk);
        checks++; if (fetch_flush !== 1'b0) begin errors++; $display("FAIL pri_flush_once got %b exp 0", fetch_flush); end
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL pri_target got req=%b addr=%h exp req=1 addr=200", ok, imem_addr); end
    endtask

    task automatic test_wrap;
        logic ok;
        apply_reset();
        wait_req(ok);
        ack_now(32'h4444_0000);
        wait_req(ok);
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_en = 1'b0;
        ack_now(32'h9999_9999);
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%b addr=%h exp req=1 addr=fffffffc", ok, imem_addr); end
        ack_now(32'h0000_0077);
        checks++; if (pc_out !== 32'hFFFF_FFFC || pcadd4_out !== 32'h0 || instr_out !== 32'h77) begin errors++; $display("FAIL wrap_out got pc=%h pc4=%h instr=%h exp fffffffc 0 77", pc_out, pcadd4_out, instr_out); end
        wait_req(ok);
        checks++; if (ok !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", ok, imem_addr); end
`ifdef IF_PERF_CNT_EN
        checks++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL wrap_fetch_cnt got %0d exp 2", fetch_cnt); end
`endif
    endtask

    task automatic test_reset_midflight;
        logic ok;
        apply_reset();
        wait_req(ok);
        rst = 1'b1;
        #1;
        checks++; if ({imem_req, fetch_stall} !== 2'b01) begin errors++; $display("FAIL mid_abandon got req=%b stall=%b exp 0 1", imem_req, fetch_stall); end
        imem_ack = 1'b1;
        imem_rdata = 32'h6666_6666;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        checks++; if ({instr_valid, imem_req} !== 2'b01 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_stale_ack got valid=%b req=%b addr=%h exp 0 1 0", instr_valid, imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_id_stall();
        test_redirect_wait();
        test_redirect_priority();
        test_wrap();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000");
        $fatal(1);
    end

endmodule
